fifo_rd_ctrl: RTL

//  Read-side master for the 8-deep FIFO. On a start pulse it pops burst_len words
//  (1..8) via rd_en and forwards them downstream over a valid/ready stream.
//  It never issues a read to an empty FIFO and absorbs downstream stalls in a
//  2-entry buffer. It sits between the FIFO and any stream consumer, such as a UART TX or bus writer.

---
 rtl/fifo_rd_ctrl_pkg.sv | 31 +++
 rtl/fifo_rd_ctrl_if.sv | 21 ++
 rtl/fifo_rd_skid.sv | 64 ++++++
 rtl/fifo_rd_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/fifo_rd_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fifo_rd_ctrl_pkg
// Purpose : Shared definitions for the FIFO read-side master: FIFO depth,
//           controller state encoding and the burst-length clamp helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fifo_rd_ctrl_pkg;

  // Depth of the FIFO this master drains; also the largest burst it will run.
  localparam int unsigned c_depth = 8;

  // Controller states; the encoding is visible on debug taps, so it is fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  // A request larger than the FIFO can ever hold is reduced to the FIFO depth.
  function automatic logic [3:0] clamp_len(input logic [3:0] req,
                                           input logic [3:0] depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fifo_rd_ctrl_if
// Purpose : Valid/ready stream between the FIFO read master and a consumer.
// Ports   : m_data  - stream word (master -> slave)
//           m_valid - word present, held stable until accepted
//           m_ready - consumer accepts when m_valid & m_ready
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_rd_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fifo_rd_skid
// Purpose : Two-entry FIFO-ordered buffer that absorbs downstream stalls.
// Ports   : clk, reset_n - clock, synchronous active-low reset
//           push, din    - write din at the tail
//           pop          - drop the head entry (ignored when empty)
//           dout         - head entry
//           occ          - number of stored entries (0..2)
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rd_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        occ
);

  logic [1:0][DATA_W-1:0] mem_q, mem_d;
  logic                   head_q, head_d;
  logic [1:0]             occ_q, occ_d;
  logic                   do_push, do_pop, tail;

  always_comb begin
    do_pop  = pop & (occ_q != 2'd0);
    // When full, a push is only accepted alongside a pop of the head.
    do_push = push & ((occ_q != 2'd2) | do_pop);
    // With two entries the tail wraps onto the head slot being popped.
    tail    = head_q ^ occ_q[0];
    mem_d   = mem_q;
    head_d  = head_q;
    occ_d   = occ_q;
    if (do_push) mem_d[tail] = din;
    if (do_pop)  head_d = ~head_q;
    case ({do_push, do_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q  <= '0;
      head_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      occ_q  <= occ_d;
    end
  end

  assign dout = mem_q[head_q];
  assign occ  = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fifo_rd_ctrl
// Purpose : Read-side master for the FIFO. On start it pops up to DEPTH words
//           and forwards them over a valid/ready stream, never reading an
//           empty FIFO and buffering up to two words across consumer stalls.
// Ports   : clk, reset_n           - clock, synchronous active-low reset
//           start, burst_len       - burst request (accepted only when idle)
//           dout, data_count       - FIFO read data and occupancy
//           rd_ack, rd_err         - FIFO read response, cycle after rd_en
//           rd_en                  - FIFO pop request
//           m_if (master)          - outgoing valid/ready stream
//           busy, done, err        - status: active, end pulse, sticky error
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = c_depth
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        burst_len,
  input  logic [DATA_W-1:0] dout,
  input  logic [3:0]        data_count,
  input  logic              rd_ack,
  input  logic              rd_err,
  output logic              rd_en,
  fifo_rd_ctrl_if.master    m_if,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] c_len_max = 4'(DEPTH);

  state_e      state_q, state_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  issued_q, issued_d;
  logic [3:0]  recvd_q, recvd_d;
  logic        inflight_q, inflight_d;
  logic        err_q, err_d;

  logic        active, push, pop, fifo_err;
  logic [1:0]  occ;
  logic [2:0]  pending;
  logic [3:0]  req_len;
  logic [DATA_W-1:0] head;

  assign active   = (state_q != ST_IDLE);
  // Responses are ignored while idle: nothing can legitimately be pending.
  assign push     = rd_ack & active;
  assign fifo_err = rd_err & active;
  assign pop      = (occ != 2'd0) & m_if.m_ready;
  // Words already buffered plus the one on its way back from the FIFO.
  assign pending  = {1'b0, occ} + {2'b00, inflight_q};
  assign req_len  = clamp_len(burst_len, c_len_max);

  // data_count already reflects a pop issued last cycle, so the in-flight
  // read is subtracted conservatively; reset blocks a pop in the reset cycle.
  assign rd_en = reset_n & (state_q == ST_READ) & (issued_q < len_q)
               & (data_count > {3'b000, inflight_q}) & (pending < 3'd2);

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (dout),
    .pop     (pop),
    .dout    (head),
    .occ     (occ)
  );

  assign m_if.m_data  = head;
  assign m_if.m_valid = (occ != 2'd0);
  assign busy         = active;
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q + {3'b000, rd_en};
    recvd_d    = recvd_q + {3'b000, push};
    inflight_d = rd_en;
    err_d      = err_q | fifo_err;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = req_len;
          issued_d = 4'd0;
          recvd_d  = 4'd0;
          err_d    = 1'b0;
          state_d  = (req_len == 4'd0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (fifo_err)               state_d = ST_ERROR;
        else if (issued_d == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_err) state_d = ST_ERROR;
        else if ((recvd_q == len_q) && (occ == 2'd0)) state_d = ST_DONE;
      end
      ST_ERROR: begin
        // Stop reading but let buffered and in-flight words reach the consumer.
        err_d = 1'b1;
        if ((occ == 2'd0) && !inflight_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      len_q      <= 4'd0;
      issued_q   <= 4'd0;
      recvd_q    <= 4'd0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      recvd_q    <= recvd_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire
